// File: rtl/psx_frame_decoder.sv
// rtl/psx_frame_decoder.sv - PSX digital-pad poll frame decoder
// Validates each ATT-low frame's header and publishes buttons plus press/release edge masks.
module psx_frame_decoder #(
  parameter logic [7:0] EXP_ID    = 8'h41,
  parameter logic [7:0] EXP_READY = 8'h5A,
  parameter int         TIMEOUT   = 16,
  parameter int         CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             att,
  input  logic [7:0]       rx_byte,
  input  logic             rx_valid,
  output logic [15:0]      buttons,
  output logic             buttons_vld,
  output logic [15:0]      pressed,
  output logic [15:0]      released,
  output logic             frame_ok,
  output logic             frame_err,
  output logic [CNT_W-1:0] err_count
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, B0, B1, B2, B3, B4, WAIT_END, ABORT} state_t;

  state_t          state, state_n;
  logic            att_q, armed, fall, rise;
  logic [TW-1:0]   timer, timer_n;
  logic [7:0]      lo, lo_n, hi, hi_n;
  logic            commit, reject;
  logic [15:0]     new_btn;

  // armed only goes high once att has been seen high, so att held low out of reset
  // cannot masquerade as a falling edge.
  assign fall    = armed & att_q & ~att;
  assign rise    = ~att_q & att;
  assign new_btn = ~{hi_n, lo_n};

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      att_q       <= 1'b1;
      armed       <= att;
      timer       <= '0;
      lo          <= '0;
      hi          <= '0;
      buttons     <= '0;
      buttons_vld <= 1'b0;
      pressed     <= '0;
      released    <= '0;
      frame_ok    <= 1'b0;
      frame_err   <= 1'b0;
      err_count   <= '0;
    end else begin
      state     <= state_n;
      att_q     <= att;
      armed     <= armed | att;
      timer     <= timer_n;
      lo        <= lo_n;
      hi        <= hi_n;
      frame_ok  <= commit;
      frame_err <= reject;
      pressed   <= commit ? (new_btn & ~buttons) : '0;
      released  <= commit ? (buttons & ~new_btn) : '0;
      if (commit) begin
        buttons     <= new_btn;
        buttons_vld <= 1'b1;
      end
      if (reject && !(&err_count))
        err_count <= err_count + 1'b1;
    end
  end

  always_comb begin
    state_n = state;
    timer_n = timer;
    lo_n    = lo;
    hi_n    = hi;
    commit  = 1'b0;
    reject  = 1'b0;
    case (state)
      IDLE: begin
        if (fall) begin
          state_n = B0;
          timer_n = '0;
        end
      end
      B0, B1, B2, B3, B4: begin
        if (rx_valid) begin
          timer_n = '0;
          case (state)
            B0:      state_n = B1;
            B1:      state_n = (rx_byte == EXP_ID) ? B2 : ABORT;
            B2:      state_n = (rx_byte == EXP_READY) ? B3 : ABORT;
            B3: begin
              lo_n    = rx_byte;
              state_n = B4;
            end
            default: begin
              hi_n    = rx_byte;
              state_n = WAIT_END;
            end
          endcase
        end else if (timer == TW'(TIMEOUT - 1)) begin
          state_n = ABORT;
          timer_n = '0;
        end else begin
          timer_n = timer + 1'b1;
        end
      end
      WAIT_END: begin
        if (rx_valid) state_n = ABORT;
      end
      ABORT: ;
      default: state_n = IDLE;
    endcase
    // The byte of this cycle has already been applied, so a 5th byte arriving with rise commits.
    if (rise && state != IDLE) begin
      commit  = (state_n == WAIT_END);
      reject  = (state_n != WAIT_END);
      state_n = IDLE;
      timer_n = '0;
    end
  end

endmodule
